smvm_stream_feeder: RTL and testbench
=====================================

SMVM_STREAM_FEEDER -- requirements
Module: smvm_stream_feeder

Interface
REQ-001 Parameter: NZ_DEPTH, default 64, nonzero buffer entries.
REQ-002 Parameter: K, default 4, ALU group size; the padding unit.
REQ-003 Parameter: DRAIN_TIMEOUT, default 255, max cycles to wait for result drain.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: s_valid  in  1  host word valid.
REQ-007 Port: s_ready  out  1  feeder accepts host word.
REQ-008 Port: s_last  in  1  final nonzero of frame.
REQ-009 Port: s_data  in  8  rows / cols / vector element / nonzero value.
REQ-010 Port: s_idx  in  7  nonzero column index.
REQ-011 Port: s_flag  in  1  nonzero starts a new row (IPV bit).
REQ-012 Port: val_in  out  8  SMVM value lane.
REQ-013 Port: col_in  out  3  SMVM low index lane.
REQ-014 Port: ipv_in  out  1  SMVM IPV / mid index lane.
REQ-015 Port: in_valid  out  1  SMVM stream valid.
REQ-016 Port: smvm_out_valid  in  1  SMVM out_valid, drain detection.
REQ-017 Port: busy  out  1  frame loaded or in flight.
REQ-018 Port: err  out  1  sticky: nonzero overflow or drain timeout; cleared by next accepted rows word.

Function
REQ-019 Host frame order SHALL be: rows (s_data, 1..128), cols (s_data, 1..128), cols vector words (s_data), then nonzeros (s_data, s_idx, s_flag), s_last marking the final nonzero.
REQ-020 A word SHALL transfer when s_valid && s_ready; s_ready SHALL be high only in LOAD_* states.
REQ-021 FSM states SHALL be: LOAD_ROWS -> LOAD_COLS -> LOAD_VEC (cols words) -> LOAD_NZ (until s_last) -> EMIT -> DRAIN -> LOAD_ROWS.
REQ-022 Nonzeros beyond NZ_DEPTH SHALL be discarded and err set; s_last still ends the frame.
REQ-023 EMIT SHALL start the cycle after the s_last handshake; in_valid SHALL stay high for every EMIT cycle, no gaps.
REQ-024 EMIT sequence: cycle 0 rows, cycle 1 cols, next cols cycles vector[0..cols-1] on val_in, then per nonzero a VAL cycle then an IDX cycle.
REQ-025 Header and IDX cycles SHALL carry 12-bit word W zero-extended: val_in=W[11:4], ipv_in=W[3], col_in=W[2:0].
REQ-026 VAL cycle: val_in=value, ipv_in=s_flag captured, col_in=0.
REQ-027 Vector cycles: val_in=element, ipv_in=0, col_in=0.
REQ-028 When in_valid is low, val_in, ipv_in, col_in SHALL be 0.
REQ-029 Burst length SHALL be 2 + cols + 2*N, N = emitted nonzero count.
REQ-030 DRAIN SHALL return to LOAD_ROWS on the first smvm_out_valid falling edge, or after DRAIN_TIMEOUT cycles with smvm_out_valid never seen high (err set).
REQ-031 busy SHALL be high from the first rows handshake until DRAIN exits.
REQ-032 A frame with zero nonzeros (s_last on no word) is impossible by protocol; s_last is sampled only in LOAD_NZ.

Reset
REQ-033 rst SHALL force LOAD_ROWS, clear all counters, and clear the buffers' valid counts, even mid-EMIT.
REQ-034 Reset values: s_ready=0 during reset, then 1 the cycle after rst deasserts; in_valid=0, val_in=0, col_in=0, ipv_in=0, busy=0, err=0.

Configuration
REQ-035 Macro FEEDER_PAD_EN: defined -> N SHALL be the captured count rounded up to a multiple of K, pad entries val=0, ipv=0, index=0; undefined -> N equals the captured count, no padding.

Verification
REQ-036 rows=2, cols=4, vec={1,2,3,4}, 4 nonzeros -> in_valid high 14 cycles; cycle0 W=2, cycle1 W=4, cycles 2-5 val_in 1..4.
REQ-037 3 nonzeros, FEEDER_PAD_EN defined -> 4 VAL/IDX pairs, last pair all zero, burst 2+cols+8; undefined -> burst 2+cols+6.
REQ-038 Nonzero column 100 -> IDX cycle val_in=6, ipv_in=0, col_in=4.
REQ-039 NZ_DEPTH+2 nonzeros -> err=1, exactly NZ_DEPTH (padded) pairs emitted.
REQ-040 smvm_out_valid held low after EMIT -> DRAIN exits after 255 cycles, err=1, s_ready=1.
REQ-041 rst asserted mid-EMIT -> next cycle in_valid=0, busy=0, state LOAD_ROWS.

Source files
------------

// File: rtl/smvm_stream_feeder_if.sv
// Host-side load bus and SMVM-side stream lanes for smvm_stream_feeder.
// slave = feeder view, master = host/SMVM view.
interface smvm_stream_feeder_if;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;
    logic [7:0] s_data;
    logic [6:0] s_idx;
    logic       s_flag;
    logic [7:0] val_in;
    logic [2:0] col_in;
    logic       ipv_in;
    logic       in_valid;
    logic       smvm_out_valid;
    logic       busy;
    logic       err;

    modport slave (
        input  s_valid, s_last, s_data, s_idx, s_flag, smvm_out_valid,
        output s_ready, val_in, col_in, ipv_in, in_valid, busy, err
    );

    modport master (
        output s_valid, s_last, s_data, s_idx, s_flag, smvm_out_valid,
        input  s_ready, val_in, col_in, ipv_in, in_valid, busy, err
    );
endinterface

// File: rtl/smvm_stream_feeder.sv
// Buffers one SMVM frame (header, vector, nonzeros) from the host and replays it as a gap-free burst.
// Optional FEEDER_PAD_EN: pad the nonzero list to a multiple of K with all-zero pairs.
module smvm_stream_feeder #(
    parameter int unsigned NZ_DEPTH      = 64,
    parameter int unsigned K             = 4,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst,
    smvm_stream_feeder_if.slave bus
);
    localparam int unsigned AW = (NZ_DEPTH > 1) ? $clog2(NZ_DEPTH) : 1;
    localparam int unsigned PW = $clog2(NZ_DEPTH + K) + 1;
    localparam int unsigned GW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
`ifdef FEEDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {LOAD_ROWS, LOAD_COLS, LOAD_VEC, LOAD_NZ, EMIT, DRAIN} state_e;
    typedef enum logic [2:0] {PH_ROWS, PH_COLS, PH_VEC, PH_VAL, PH_IDX} phase_e;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [7:0]    rows_q, rows_d;
    logic [7:0]    cols_q, cols_d;
    logic [7:0]    vcnt_q, vcnt_d;
    logic [PW-1:0] nz_cnt_q, nz_cnt_d;
    logic [PW-1:0] pair_q, pair_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          seen_q, seen_d;
    logic          prev_q, prev_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;

    logic [7:0] vec_mem [128];
    logic [7:0] nz_val  [NZ_DEPTH];
    logic [6:0] nz_idx  [NZ_DEPTH];
    logic       nz_flag [NZ_DEPTH];

    logic        vec_we, nz_we, hs, load_st, pair_live, last_pair, grp_wrap;
    logic [11:0] word;

    assign load_st     = (state_q == LOAD_ROWS) || (state_q == LOAD_COLS) ||
                         (state_q == LOAD_VEC)  || (state_q == LOAD_NZ);
    assign bus.s_ready = ready_q && load_st;
    assign bus.busy    = (state_q != LOAD_ROWS);
    assign bus.err     = err_q;
    assign hs          = bus.s_valid && bus.s_ready;
    assign pair_live   = (pair_q < nz_cnt_q);
    assign grp_wrap    = (grp_q == GW'(K - 1));
    // With padding, the burst continues past the captured count until the K-group closes.
    assign last_pair   = ((pair_q + PW'(1)) >= nz_cnt_q) && (!PAD_EN || grp_wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD_ROWS;
            phase_q  <= PH_ROWS;
            rows_q   <= '0;
            cols_q   <= '0;
            vcnt_q   <= '0;
            nz_cnt_q <= '0;
            pair_q   <= '0;
            grp_q    <= '0;
            dcnt_q   <= '0;
            seen_q   <= 1'b0;
            prev_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            vcnt_q   <= vcnt_d;
            nz_cnt_q <= nz_cnt_d;
            pair_q   <= pair_d;
            grp_q    <= grp_d;
            dcnt_q   <= dcnt_d;
            seen_q   <= seen_d;
            prev_q   <= prev_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (vec_we) vec_mem[vcnt_q[6:0]] <= bus.s_data;
        if (nz_we) begin
            nz_val[nz_cnt_q[AW-1:0]]  <= bus.s_data;
            nz_idx[nz_cnt_q[AW-1:0]]  <= bus.s_idx;
            nz_flag[nz_cnt_q[AW-1:0]] <= bus.s_flag;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        vcnt_d   = vcnt_q;
        nz_cnt_d = nz_cnt_q;
        pair_d   = pair_q;
        grp_d    = grp_q;
        dcnt_d   = dcnt_q;
        seen_d   = seen_q;
        prev_d   = bus.smvm_out_valid;
        err_d    = err_q;
        ready_d  = 1'b1;
        vec_we   = 1'b0;
        nz_we    = 1'b0;
        case (state_q)
            LOAD_ROWS: if (hs) begin
                rows_d  = bus.s_data;
                err_d   = 1'b0;
                state_d = LOAD_COLS;
            end
            LOAD_COLS: if (hs) begin
                cols_d  = bus.s_data;
                vcnt_d  = '0;
                state_d = LOAD_VEC;
            end
            LOAD_VEC: if (hs) begin
                vec_we = 1'b1;
                if (vcnt_q == cols_q - 8'd1) begin
                    vcnt_d   = '0;
                    nz_cnt_d = '0;
                    state_d  = LOAD_NZ;
                end else begin
                    vcnt_d = vcnt_q + 8'd1;
                end
            end
            LOAD_NZ: if (hs) begin
                if (nz_cnt_q < PW'(NZ_DEPTH)) begin
                    nz_we    = 1'b1;
                    nz_cnt_d = nz_cnt_q + PW'(1);
                end else begin
                    err_d = 1'b1;
                end
                if (bus.s_last) begin
                    state_d = EMIT;
                    phase_d = PH_ROWS;
                    vcnt_d  = '0;
                    pair_d  = '0;
                    grp_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            EMIT: begin
                seen_d = seen_q || bus.smvm_out_valid;
                case (phase_q)
                    PH_ROWS: phase_d = PH_COLS;
                    PH_COLS: phase_d = PH_VEC;
                    PH_VEC: begin
                        if (vcnt_q == cols_q - 8'd1) phase_d = PH_VAL;
                        else vcnt_d = vcnt_q + 8'd1;
                    end
                    PH_VAL: phase_d = PH_IDX;
                    PH_IDX: begin
                        if (last_pair) begin
                            state_d = DRAIN;
                            dcnt_d  = '0;
                        end else begin
                            phase_d = PH_VAL;
                            pair_d  = pair_q + PW'(1);
                            grp_d   = grp_wrap ? '0 : grp_q + GW'(1);
                        end
                    end
                    default: phase_d = PH_ROWS;
                endcase
            end
            DRAIN: begin
                seen_d = seen_q || bus.smvm_out_valid;
                if (prev_q && !bus.smvm_out_valid) begin
                    state_d = LOAD_ROWS;
                end else if (!seen_q && !bus.smvm_out_valid &&
                             dcnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
                    state_d = LOAD_ROWS;
                    err_d   = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = LOAD_ROWS;
        endcase
    end

    always_comb begin
        word = '0;
        if (state_q == EMIT) begin
            case (phase_q)
                PH_ROWS: word = {4'b0, rows_q};
                PH_COLS: word = {4'b0, cols_q};
                PH_VEC:  word = {vec_mem[vcnt_q[6:0]], 4'b0};
                PH_VAL:  if (pair_live) word = {nz_val[pair_q[AW-1:0]], nz_flag[pair_q[AW-1:0]], 3'b0};
                PH_IDX:  if (pair_live) word = {5'b0, nz_idx[pair_q[AW-1:0]]};
                default: word = '0;
            endcase
        end
    end

    assign bus.in_valid = (state_q == EMIT);
    assign bus.val_in   = word[11:4];
    assign bus.ipv_in   = word[3];
    assign bus.col_in   = word[2:0];
endmodule

// File: tb/tb_smvm_stream_feeder.sv
// Directed bench for smvm_stream_feeder (NZ_DEPTH=8, K=4); expected bursts are hand-computed 12-bit words {val_in, ipv_in, col_in}.
module tb_smvm_stream_feeder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    smvm_stream_feeder_if bus();

    smvm_stream_feeder #(.NZ_DEPTH(8), .K(4), .DRAIN_TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic [7:0]  vec_t [0:7];
    logic [7:0]  nzv   [0:15];
    logic [6:0]  nzi   [0:15];
    logic        nzf   [0:15];
    logic [11:0] burst [0:63];
    logic [11:0] expA  [0:13];
    logic [11:0] expB  [0:9];
    int          blen;
    int          n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [6:0] ix, input logic f, input logic l);
        int unsigned w = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_idx   = ix;
        bus.s_flag  = f;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check("send_ready", {31'b0, bus.s_ready}, 32'd1);
        else step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] rows, input logic [7:0] cols, input int nnz);
        send(rows, 7'd0, 1'b0, 1'b0);
        check("busy_after_rows", {31'b0, bus.busy}, 32'd1);
        check("err_clr_rows", {31'b0, bus.err}, 32'd0);
        send(cols, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < int'(cols); i++) send(vec_t[i], 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < nnz; i++) send(nzv[i], nzi[i], nzf[i], i == nnz - 1);
    endtask

    task automatic capture(output int len);
        len = 0;
        while (bus.in_valid === 1'b1 && len < 64) begin
            burst[len] = {bus.val_in, bus.ipv_in, bus.col_in};
            len++;
            step();
        end
    endtask

    task automatic drain_pulse();
        int unsigned w = 0;
        bus.smvm_out_valid = 1'b1;
        step();
        step();
        bus.smvm_out_valid = 1'b0;
        while (bus.s_ready !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        check("drain_exit_ready", {31'b0, bus.s_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        bus.s_data = '0;
        bus.s_idx = '0;
        bus.s_flag = 1'b0;
        bus.smvm_out_valid = 1'b0;
        expA = '{12'h002, 12'h004, 12'h010, 12'h020, 12'h030, 12'h040, 12'h118,
                 12'h064, 12'h220, 12'h005, 12'h338, 12'h07F, 12'h440, 12'h008};
        expB = '{12'h003, 12'h002, 12'h090, 12'h0A0, 12'h058, 12'h001, 12'h060,
                 12'h002, 12'h078, 12'h003};

        repeat (3) step();
        check("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
        check("rst_in_valid", {31'b0, bus.in_valid}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        check("rst_lanes", {20'b0, bus.val_in, bus.ipv_in, bus.col_in}, 32'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", {31'b0, bus.s_ready}, 32'd1);

        // Frame A: rows=2 cols=4 vec 1..4, four nonzeros incl. column 100
        vec_t[0] = 8'd1; vec_t[1] = 8'd2; vec_t[2] = 8'd3; vec_t[3] = 8'd4;
        nzv[0] = 8'h11; nzi[0] = 7'd100; nzf[0] = 1'b1;
        nzv[1] = 8'h22; nzi[1] = 7'd5;   nzf[1] = 1'b0;
        nzv[2] = 8'h33; nzi[2] = 7'h7F;  nzf[2] = 1'b1;
        nzv[3] = 8'h44; nzi[3] = 7'd8;   nzf[3] = 1'b0;
        send_frame(8'd2, 8'd4, 4);
        capture(blen);
        check("A_len", blen, 32'd14);
        for (int i = 0; i < 14; i++) check($sformatf("A_word%0d", i), {20'b0, burst[i]}, {20'b0, expA[i]});
        check("A_idle_lanes", {20'b0, bus.val_in, bus.ipv_in, bus.col_in}, 32'd0);
        drain_pulse();
        check("A_busy_end", {31'b0, bus.busy}, 32'd0);
        check("A_err_end", {31'b0, bus.err}, 32'd0);

        // Frame B: three nonzeros, then SMVM stays silent so DRAIN times out
        vec_t[0] = 8'd9; vec_t[1] = 8'd10;
        nzv[0] = 8'h05; nzi[0] = 7'd1; nzf[0] = 1'b1;
        nzv[1] = 8'h06; nzi[1] = 7'd2; nzf[1] = 1'b0;
        nzv[2] = 8'h07; nzi[2] = 7'd3; nzf[2] = 1'b1;
        send_frame(8'd3, 8'd2, 3);
        capture(blen);
        check("B_len", blen, PAD ? 32'd12 : 32'd10);
        for (int i = 0; i < 10; i++) check($sformatf("B_word%0d", i), {20'b0, burst[i]}, {20'b0, expB[i]});
        if (PAD) begin
            check("B_pad_val", {20'b0, burst[10]}, 32'd0);
            check("B_pad_idx", {20'b0, burst[11]}, 32'd0);
        end
        check("B_busy_drain", {31'b0, bus.busy}, 32'd1);
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("B_drain_cycles", n, 32'd255);
        check("B_err_timeout", {31'b0, bus.err}, 32'd1);
        check("B_busy_end", {31'b0, bus.busy}, 32'd0);

        // Frame C: ten nonzeros into an eight-deep buffer
        vec_t[0] = 8'h55;
        for (int i = 0; i < 10; i++) begin
            nzv[i] = 8'h80 + 8'(i);
            nzi[i] = 7'(i);
            nzf[i] = i[0];
        end
        send_frame(8'd1, 8'd1, 10);
        capture(blen);
        check("C_len", blen, 32'd19);
        check("C_first_val", {20'b0, burst[3]}, 32'h800);
        check("C_first_idx", {20'b0, burst[4]}, 32'h000);
        check("C_last_val", {20'b0, burst[17]}, 32'h878);
        check("C_last_idx", {20'b0, burst[18]}, 32'h007);
        check("C_err_ovf", {31'b0, bus.err}, 32'd1);
        drain_pulse();
        check("C_err_sticky", {31'b0, bus.err}, 32'd1);

        // Frame D: reset lands in the middle of EMIT
        vec_t[0] = 8'd1; vec_t[1] = 8'd2; vec_t[2] = 8'd3;
        nzv[0] = 8'h12; nzi[0] = 7'd9; nzf[0] = 1'b1;
        send_frame(8'd4, 8'd3, 1);
        check("D_emit_start", {31'b0, bus.in_valid}, 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        check("D_rst_in_valid", {31'b0, bus.in_valid}, 32'd0);
        check("D_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("D_rst_ready", {31'b0, bus.s_ready}, 32'd0);
        check("D_rst_err", {31'b0, bus.err}, 32'd0);
        rst = 1'b0;
        step();
        check("D_ready_after", {31'b0, bus.s_ready}, 32'd1);

        // Frame E: max rows, single-element vector, one nonzero at column 0
        vec_t[0] = 8'hFF;
        nzv[0] = 8'hAB; nzi[0] = 7'd0; nzf[0] = 1'b0;
        send_frame(8'd128, 8'd1, 1);
        capture(blen);
        check("E_len", blen, PAD ? 32'd11 : 32'd5);
        check("E_rows", {20'b0, burst[0]}, 32'h080);
        check("E_vec", {20'b0, burst[2]}, 32'hFF0);
        check("E_val", {20'b0, burst[3]}, 32'hAB0);
        check("E_idx", {20'b0, burst[4]}, 32'h000);
        drain_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
